// File: rtl/mont_pkg.sv
// Shared types and constants for the Montgomery domain blocks
// (mont_conversion and mont_reduction).
package mont_pkg;

  localparam int DEFAULT_WIDTH = 512;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mont_state_e;

endpackage : mont_pkg

// File: rtl/mod_double.sv
// Combinational modular doubler: returns (2*acc) mod n, assuming acc < n.
module mod_double #(
  parameter int WIDTH = 512
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] n_i,
  output logic [WIDTH-1:0] dbl_o
);

  logic [WIDTH:0] dblFull;
  logic           geN;

  assign dblFull = {acc_i, 1'b0};
  assign geN     = (dblFull >= {1'b0, n_i});

  // The result is below n, so subtracting modulo 2^WIDTH loses nothing.
  assign dbl_o = geN ? (dblFull[WIDTH-1:0] - n_i) : dblFull[WIDTH-1:0];

endmodule : mod_double

// File: rtl/mont_conversion.sv
// Converts x into Montgomery form (x * 2^WIDTH) mod N by WIDTH modular doublings.
// Optional input range check enabled with macro MONT_RANGE_CHECK_EN.
module mont_conversion
  import mont_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] N,
  input  logic             valid_in,
  output logic [WIDTH-1:0] x_mont,
  output logic             valid_out,
  output logic             busy_out,
  output logic             err_out
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  mont_state_e      state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] xMont_q, xMont_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] dbl;

`ifdef MONT_RANGE_CHECK_EN
  logic             err_q, err_d;
  logic             rangeBad;
  assign rangeBad = (x_in >= N);
`endif

  mod_double #(.WIDTH(WIDTH)) u_mod_double (
    .acc_i (acc_q),
    .n_i   (n_q),
    .dbl_o (dbl)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    xMont_d = xMont_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
`ifdef MONT_RANGE_CHECK_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (valid_in) begin
`ifdef MONT_RANGE_CHECK_EN
          if (rangeBad) begin
            err_d = 1'b1;
          end else begin
            acc_d   = x_in;
            n_d     = N;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = RUN;
          end
`else
          acc_d   = x_in;
          n_d     = N;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
`endif
        end
      end
      RUN: begin
        acc_d = dbl;
        cnt_d = cnt_q + CW'(1);
        // Final doubling publishes the result and frees the FSM on the same edge.
        if (cnt_q == LAST_CNT) begin
          xMont_d = dbl;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      acc_q   <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      xMont_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MONT_RANGE_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      xMont_q <= xMont_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
`ifdef MONT_RANGE_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign x_mont    = xMont_q;
  assign valid_out = valid_q;
  assign busy_out  = busy_q;
`ifdef MONT_RANGE_CHECK_EN
  assign err_out   = err_q;
`else
  assign err_out   = 1'b0;
`endif

endmodule : mont_conversion

// File: tb/tb_mont_conversion.sv
// Bench for mont_conversion: directed and random conversions at WIDTH=16 plus
// one 512-bit conversion, checked against plain modular arithmetic.
module tb_mont_conversion;

  localparam int W  = 16;
  localparam int WB = 512;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [W-1:0]  xIn, nIn, xMont;
  logic          validIn, validOut, busyOut, errOut;
  logic [WB-1:0] xBig, nBig, xMontBig;
  logic          validInBig, validOutBig, busyOutBig, errOutBig;

  int checks = 0;
  int errors = 0;

  mont_conversion #(.WIDTH(W)) dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .x_in      (xIn),
    .N         (nIn),
    .valid_in  (validIn),
    .x_mont    (xMont),
    .valid_out (validOut),
    .busy_out  (busyOut),
    .err_out   (errOut)
  );

  mont_conversion #(.WIDTH(WB)) dutBig (
    .clk_in    (clk),
    .rst_in    (rst),
    .x_in      (xBig),
    .N         (nBig),
    .valid_in  (validInBig),
    .x_mont    (xMontBig),
    .valid_out (validOutBig),
    .busy_out  (busyOutBig),
    .err_out   (errOutBig)
  );

  // Reference: Montgomery form is x * 2^W reduced mod n.
  function automatic logic [W-1:0] refMont(input logic [W-1:0] x, input logic [W-1:0] n);
    logic [63:0] prod;
    prod = (64'(x) << W) % 64'(n);
    return prod[W-1:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents one request for exactly one edge, then scrambles the inputs.
  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] n);
    xIn = x;
    nIn = n;
    validIn = 1'b1;
    @(posedge clk);
    #1;
    validIn = 1'b0;
    xIn = W'($urandom);
    nIn = W'($urandom);
  endtask

  // Follows W edges after acceptance plus a short tail; optionally pokes
  // valid_in mid-run with a different operand.
  task automatic runAndCheck(input string tag, input logic [W-1:0] exp, input int injectAt);
    int pulses;
    int pulseAt;
    pulses = 0;
    pulseAt = -1;
    checkOutput({tag, "_busy"}, 512'(busyOut), 512'(1));
    for (int k = 1; k <= W; k++) begin
      @(posedge clk);
      #1;
      if (validOut) begin
        pulses++;
        pulseAt = k;
      end
      if (k == injectAt) begin
        validIn = 1'b1;
        xIn = 16'd1;
        nIn = 16'd33227;
      end else begin
        validIn = 1'b0;
      end
    end
    checkOutput({tag, "_xmont"}, 512'(xMont), 512'(exp));
    checkOutput({tag, "_latency"}, 512'(pulseAt), 512'(W));
    checkOutput({tag, "_idle"}, 512'(busyOut), 512'(0));
    if (injectAt > 0) begin
      for (int k = 0; k < 4; k++) begin
        @(posedge clk);
        #1;
        if (validOut) pulses++;
      end
      checkOutput({tag, "_hold"}, 512'(xMont), 512'(exp));
    end
    checkOutput({tag, "_pulses"}, 512'(pulses), 512'(1));
  endtask

  initial begin
    logic [W-1:0]      rx, rn;
    logic [2*WB-1:0]   bigProd, bigMod, bigRes;
    int                cnt;
    rst = 1'b1;
    validIn = 1'b0;
    xIn = '0;
    nIn = '0;
    validInBig = 1'b0;
    xBig = '0;
    nBig = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_xmont", 512'(xMont), 512'(0));
    checkOutput("rst_valid", 512'(validOut), 512'(0));
    checkOutput("rst_busy",  512'(busyOut), 512'(0));
    checkOutput("rst_err",   512'(errOut), 512'(0));
    rst = 1'b0;

    applyStimulus(16'd46, 16'd33227);
    runAndCheck("vec46", 16'd24226, -1);
    applyStimulus(16'd1, 16'd33227);
    runAndCheck("vec1_b2b", 16'd32309, -1);
    applyStimulus(16'd0, 16'd33227);
    runAndCheck("vec0", 16'd0, -1);
    applyStimulus(16'd33226, 16'd33227);
    runAndCheck("vecMax", 16'd918, -1);
    applyStimulus(16'd46, 16'd33227);
    runAndCheck("inject", 16'd24226, 5);

    for (int i = 0; i < 6; i++) begin
      rn = W'($urandom_range(3, 65535)) | 16'd1;
      rx = W'($urandom) % rn;
      applyStimulus(rx, rn);
      runAndCheck($sformatf("rand%0d", i), refMont(rx, rn), -1);
    end

    // Reset during RUN once the counter has reached 5.
    applyStimulus(16'd100, 16'd33227);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_xmont", 512'(xMont), 512'(0));
    checkOutput("midrst_busy",  512'(busyOut), 512'(0));
    checkOutput("midrst_valid", 512'(validOut), 512'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (validOut) cnt++;
    end
    checkOutput("midrst_novalid", 512'(cnt), 512'(0));
    applyStimulus(16'd46, 16'd33227);
    runAndCheck("afterRst", 16'd24226, -1);

    // Out-of-range operand: rejected when checked, otherwise must still finish.
    applyStimulus(16'd33227, 16'd33227);
`ifdef MONT_RANGE_CHECK_EN
    checkOutput("range_err",  512'(errOut), 512'(1));
    checkOutput("range_busy", 512'(busyOut), 512'(0));
    cnt = 0;
    for (int k = 0; k < W + 2; k++) begin
      @(posedge clk);
      #1;
      if (validOut) cnt++;
      if (k == 0) checkOutput("range_errPulse", 512'(errOut), 512'(0));
    end
    checkOutput("range_novalid", 512'(cnt), 512'(0));
`else
    checkOutput("range_errTied", 512'(errOut), 512'(0));
    for (int k = 0; k < W + 2; k++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("range_noLock", 512'(busyOut), 512'(0));
`endif
    applyStimulus(16'd1, 16'd33227);
    runAndCheck("afterRange", 16'd32309, -1);

    // Full-width conversion, bounded wait for the result pulse.
    nBig = 512'd8446001084112110468007350899866059366449315229085619820000217473402760874334633786644317357840696578249028889585050688594982676710791149734896799707926013;
    xBig = 512'd82289494155958622552101842259948196324913095467108646453504357986875686437490;
    bigProd = {xBig, 512'b0};
    bigMod  = {512'b0, nBig};
    bigRes  = bigProd % bigMod;
    validInBig = 1'b1;
    @(posedge clk);
    #1;
    validInBig = 1'b0;
    nBig = '0;
    cnt = 0;
    while (!validOutBig && cnt < WB + 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    checkOutput("big_latency", 512'(cnt), 512'(WB));
    checkOutput("big_xmont", xMontBig, bigRes[WB-1:0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mont_conversion
